// File: rtl/axi_pcie_pkg.sv
// rtl/axi_pcie_pkg.sv - shared response codes, beat size, FSM states and byte parity
package axi_pcie_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BEAT_LOG2   = 5;
    localparam int WORD_ADDR_W = 64 - BEAT_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    function automatic logic [31:0] byte_par(input logic [255:0] data);
        logic [31:0] par;
        for (int i = 0; i < 32; i++) begin
            par[i] = ~^data[8*i +: 8];
        end
        return par;
    endfunction

    // Encodings order by severity, so the worse response is the larger one.
    function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - dual-port 256-bit RAM, byte-enabled write, registered read-first read
module axi_slave_mem #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [255:0]          wr_data,
    input  logic [31:0]           wr_strb,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [255:0]          rd_data
);

    logic [255:0] mem [0:(1 << DEPTH_LOG2)-1];
    logic [255:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 32; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Sampling the array on the same edge as a write yields the old word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_pcie_slave_regfile.sv
// rtl/axi_pcie_slave_regfile.sv - AXI4 slave over on-chip RAM; AXI_SLAVE_PARITY_CHECK_EN enables write parity checking
module axi_pcie_slave_regfile
    import axi_pcie_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 6,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [63:0]  S_AXI_AWADDR,
    input  logic [7:0]   S_AXI_AWID,
    input  logic [7:0]   S_AXI_AWLEN,
    input  logic         S_AXI_AWVALID,
    output logic         S_AXI_AWREADY,
    input  logic [255:0] S_AXI_WDATA,
    input  logic [31:0]  S_AXI_WDATA_PAR,
    input  logic [31:0]  S_AXI_WSTRB,
    input  logic         S_AXI_WLAST,
    input  logic         S_AXI_WVALID,
    output logic         S_AXI_WREADY,
    output logic [7:0]   S_AXI_BID,
    output logic [1:0]   S_AXI_BRESP,
    output logic         S_AXI_BVALID,
    input  logic         S_AXI_BREADY,
    input  logic [63:0]  S_AXI_ARADDR,
    input  logic [7:0]   S_AXI_ARID,
    input  logic [7:0]   S_AXI_ARLEN,
    input  logic         S_AXI_ARVALID,
    output logic         S_AXI_ARREADY,
    output logic [255:0] S_AXI_RDATA,
    output logic [31:0]  S_AXI_RDATA_PAR,
    output logic [7:0]   S_AXI_RID,
    output logic [1:0]   S_AXI_RRESP,
    output logic         S_AXI_RLAST,
    output logic         S_AXI_RVALID,
    input  logic         S_AXI_RREADY
);

    typedef logic [WORD_ADDR_W-1:0] waddr_t;

    function automatic logic in_window(input waddr_t wa);
        return wa[WORD_ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[63:BEAT_LOG2+DEPTH_LOG2];
    endfunction

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[BEAT_LOG2-1:0], S_AXI_ARADDR[BEAT_LOG2-1:0]};

    w_state_t   w_state_q, w_state_d;
    logic [7:0] w_id_q, w_id_d, w_len_q, w_len_d;
    waddr_t     w_addr_q, w_addr_d;
    logic [8:0] w_cnt_q, w_cnt_d;
    logic [1:0] w_resp_q, w_resp_d, beat_resp;
    logic       aw_hs, w_hs, b_hs, w_in_win, w_par_err, mem_wr_en;

    assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
    assign b_hs     = S_AXI_BVALID && S_AXI_BREADY;
    assign w_in_win = in_window(w_addr_q);

`ifdef AXI_SLAVE_PARITY_CHECK_EN
    assign w_par_err = |(S_AXI_WSTRB & (S_AXI_WDATA_PAR ^ byte_par(S_AXI_WDATA)));
`else
    logic unused_wdata_par;
    assign unused_wdata_par = ^S_AXI_WDATA_PAR;
    assign w_par_err = 1'b0;
`endif

    assign beat_resp = !w_in_win ? RESP_DECERR : (w_par_err ? RESP_SLVERR : RESP_OKAY);
    assign mem_wr_en = w_hs && w_in_win && !w_par_err;

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && S_AXI_WLAST) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        w_id_d   = w_id_q;
        w_len_d  = w_len_q;
        w_addr_d = w_addr_q;
        w_cnt_d  = w_cnt_q;
        w_resp_d = w_resp_q;
        if (aw_hs) begin
            w_id_d   = S_AXI_AWID;
            w_len_d  = S_AXI_AWLEN;
            w_addr_d = S_AXI_AWADDR[63:BEAT_LOG2];
            w_cnt_d  = '0;
            w_resp_d = RESP_OKAY;
        end else if (w_hs) begin
            w_addr_d = w_addr_q + WORD_ADDR_W'(1);
            w_cnt_d  = w_cnt_q + 9'd1;
            w_resp_d = worse_resp(w_resp_q, beat_resp);
            // A burst terminated by WLAST at the wrong beat count is a slave error.
            if (S_AXI_WLAST && (w_cnt_q != {1'b0, w_len_q})) begin
                w_resp_d = worse_resp(w_resp_d, RESP_SLVERR);
            end
        end
    end

    always_comb begin
        S_AXI_AWREADY = (w_state_q == W_IDLE);
        S_AXI_WREADY  = (w_state_q == W_DATA);
        S_AXI_BVALID  = (w_state_q == W_RESP);
    end

    assign S_AXI_BID   = w_id_q;
    assign S_AXI_BRESP = w_resp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_addr_q  <= '0;
            w_cnt_q   <= '0;
            w_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_addr_q  <= w_addr_d;
            w_cnt_q   <= w_cnt_d;
            w_resp_q  <= w_resp_d;
        end
    end

    r_state_t     r_state_q, r_state_d;
    logic [7:0]   r_id_q, r_id_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    waddr_t       r_addr_q, r_addr_d, rd_addr;
    logic [1:0]   r_resp_q, r_resp_d;
    logic         r_last_q, r_last_d;
    logic         ar_hs, r_hs, r_advance, rd_in_win, mem_rd_en;
    logic [255:0] mem_rd_data;

    // r_addr_q always points at the beat to fetch on the next R handshake.
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs      = S_AXI_RVALID && S_AXI_RREADY;
    assign r_advance = r_hs && !r_last_q;
    assign rd_addr   = ar_hs ? S_AXI_ARADDR[63:BEAT_LOG2] : r_addr_q;
    assign rd_in_win = in_window(rd_addr);
    assign mem_rd_en = (ar_hs || r_advance) && rd_in_win;

    always_comb begin
        r_state_d = r_state_q;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) r_state_d = R_DATA;
        end else if (r_hs && r_last_q) begin
            r_state_d = R_IDLE;
        end
    end

    always_comb begin
        r_id_d   = r_id_q;
        r_len_d  = r_len_q;
        r_cnt_d  = r_cnt_q;
        r_addr_d = r_addr_q;
        r_resp_d = r_resp_q;
        r_last_d = r_last_q;
        if (ar_hs) begin
            r_id_d   = S_AXI_ARID;
            r_len_d  = S_AXI_ARLEN;
            r_cnt_d  = '0;
            r_addr_d = rd_addr + WORD_ADDR_W'(1);
            r_resp_d = rd_in_win ? RESP_OKAY : RESP_DECERR;
            r_last_d = (S_AXI_ARLEN == 8'd0);
        end else if (r_advance) begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = r_addr_q + WORD_ADDR_W'(1);
            r_resp_d = rd_in_win ? RESP_OKAY : RESP_DECERR;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
        end else if (r_hs) begin
            r_last_d = 1'b0;
        end
    end

    always_comb begin
        S_AXI_ARREADY = (r_state_q == R_IDLE);
        S_AXI_RVALID  = (r_state_q == R_DATA);
    end

    assign S_AXI_RID       = r_id_q;
    assign S_AXI_RRESP     = r_resp_q;
    assign S_AXI_RLAST     = r_last_q;
    assign S_AXI_RDATA     = (r_resp_q == RESP_DECERR) ? '0 : mem_rd_data;
    assign S_AXI_RDATA_PAR = byte_par(S_AXI_RDATA);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            r_last_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
        end
    end

    axi_slave_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (mem_wr_en),
        .wr_idx (w_addr_q[DEPTH_LOG2-1:0]),
        .wr_data(S_AXI_WDATA),
        .wr_strb(S_AXI_WSTRB),
        .rd_en  (mem_rd_en),
        .rd_idx (rd_addr[DEPTH_LOG2-1:0]),
        .rd_data(mem_rd_data)
    );

endmodule
